// File: rtl/vr_pkg.sv
// Shared defaults and helpers for the buffered valid/ready receiver.
package vr_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 4;
  localparam int CNT_WIDTH_DEF  = 32;

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;

  // Occupancy runs 0..depth inclusive, so it needs one more code than an address.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vr_fifo_mem.sv
// Receiver FIFO storage: synchronous write, asynchronous (show-ahead) read.
// No reset on the array; validity is tracked by the controller's level.
module vr_fifo_mem
  import vr_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vr_buffered_receiver.sv
// Valid/ready receiver buffering words in a DEPTH-entry FIFO; one-cycle latency to out_data.
// Drops ready while full; counts accepted words and flags upstream handshake violations.
module vr_buffered_receiver
  import vr_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  output logic                          ready,
  input  logic [DATA_WIDTH-1:0]         data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [level_width(DEPTH)-1:0] level,
  output logic [CNT_WIDTH-1:0]          rx_count,
  output logic                          proto_err
);

  localparam int LW = level_width(DEPTH);
  localparam int AW = addr_width(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  prev_valid;
  logic                  prev_ready;
  logic [DATA_WIDTH-1:0] prev_data;
  logic                  violation;

  assign ready     = !rst && (level != FULL_LEVEL);
  assign out_valid = !rst && (level != '0);
  assign push      = valid && ready;
  assign pop       = out_valid && out_ready;

  // A word offered but not taken must be held with identical data next cycle.
  assign violation = prev_valid && !prev_ready && (!valid || (data != prev_data));

  vr_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(data),
    .raddr(rd_ptr),
    .rdata(out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count <= '0;
    end else if (push) begin
      rx_count <= rx_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
      prev_data  <= '0;
      proto_err  <= 1'b0;
    end else begin
      prev_valid <= valid;
      prev_ready <= ready;
      prev_data  <= data;
      if (violation) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vr_buffered_receiver.sv
// Bench for vr_buffered_receiver: directed scenarios plus randomized traffic against a queue model.
module tb_vr_buffered_receiver;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [DW-1:0] data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic [CW-1:0] rx_count;
  logic          proto_err;

  int nchk = 0;
  int nerr = 0;

  // Reference model: word queue, accept counter, sticky error and last-cycle handshake.
  logic [DW-1:0] q[$];
  logic [CW-1:0] m_cnt;
  logic          m_err;
  logic          m_pv, m_pr;
  logic [DW-1:0] m_pd;

  vr_buffered_receiver #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .rx_count(rx_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    q.delete();
    m_cnt = '0;
    m_err = 1'b0;
    m_pv  = 1'b0;
    m_pr  = 1'b0;
    m_pd  = '0;
  endfunction

  // Advance one clock, applying the model's view of this cycle's handshake.
  task automatic tick();
    bit m_ready, push, pop;
    @(negedge clk);
    m_ready = (q.size() < DEPTH);
    push = valid && m_ready;
    pop  = (q.size() > 0) && out_ready;
    if (m_pv && !m_pr && (!valid || data != m_pd)) m_err = 1'b1;
    m_pv = valid;
    m_pr = m_ready;
    m_pd = data;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(data);
      m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    nchk++;
    if (ready !== 1'b0 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_hold: ready=%b out_valid=%b, need 0/0", ready, out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    nchk++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || level !== '0 || rx_count !== '0 || proto_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release: ready=%b out_valid=%b level=%0d rx_count=%0d proto_err=%b, need 1/0/0/0/0",
               ready, out_valid, level, rx_count, proto_err);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = words[i];
      tick();
      nchk++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || level !== LW'(i + 1)) begin
        nerr++;
        $display("FAIL fill_%0d: out_valid=%b out_data=%h level=%0d, need 1/11/%0d",
                 i, out_valid, out_data, level, i + 1);
      end
    end
    data = 8'h55;
    repeat (2) tick();
    nchk++;
    if (ready !== 1'b0 || level !== LW'(4) || rx_count !== 32'd4) begin
      nerr++;
      $display("FAIL full_hold: ready=%b level=%0d rx_count=%0d, need 0/4/4", ready, level, rx_count);
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp_words [4];
    exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33; exp_words[3] = 8'h44;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid = (i <= 1);
      data  = 8'h55;
      #1;
      nchk++;
      if (out_data !== exp_words[i] || ready !== (i != 0)) begin
        nerr++;
        $display("FAIL drain_%0d: out_data=%h ready=%b, need %h/%b", i, out_data, ready, exp_words[i], i != 0);
      end
      tick();
    end
    valid = 1'b0;
    #1;
    nchk++;
    if (out_valid !== 1'b1 || out_data !== 8'h55 || level !== LW'(1)) begin
      nerr++;
      $display("FAIL drain_55: out_valid=%b out_data=%h level=%0d, need 1/55/1", out_valid, out_data, level);
    end
    tick();
    nchk++;
    if (out_valid !== 1'b0 || level !== '0 || rx_count !== 32'd5 || proto_err !== 1'b0) begin
      nerr++;
      $display("FAIL drain_empty: out_valid=%b level=%0d rx_count=%0d proto_err=%b, need 0/0/5/0",
               out_valid, level, rx_count, proto_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      valid = (k < 20);
      data  = DW'(k);
      #1;
      if (k >= 1) begin
        nchk++;
        if (level !== LW'(1) || out_data !== DW'(k - 1) || ready !== 1'b1) begin
          nerr++;
          $display("FAIL stream_%0d: level=%0d out_data=%h ready=%b, need 1/%h/1", k, level, out_data, ready, k - 1);
        end
      end
      tick();
    end
    valid = 1'b0;
    nchk++;
    if (level !== '0 || out_valid !== 1'b0 || rx_count !== 32'd20) begin
      nerr++;
      $display("FAIL stream_end: level=%0d out_valid=%b rx_count=%0d, need 0/0/20", level, out_valid, rx_count);
    end
  endtask

  task automatic test_random();
    logic hold;
    do_reset();
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        valid = ($urandom_range(0, 99) < 60);
        data  = DW'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < 45);
      #1;
      nchk++;
      if (ready !== (q.size() < DEPTH) || out_valid !== (q.size() > 0) || level !== LW'(q.size()) ||
          rx_count !== m_cnt || proto_err !== m_err || (q.size() > 0 && out_data !== q[0])) begin
        nerr++;
        $display("FAIL random_%0d: ready=%b out_valid=%b level=%0d out_data=%h rx_count=%0d proto_err=%b, need %b/%b/%0d/%h/%0d/%b",
                 c, ready, out_valid, level, out_data, rx_count, proto_err,
                 q.size() < DEPTH, q.size() > 0, q.size(), (q.size() > 0) ? q[0] : 8'h00, m_cnt, m_err);
      end
      hold = valid && (q.size() >= DEPTH);
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic test_protocol();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid = 1'b1;
      data  = DW'(8'h60 + i);
      tick();
    end
    data = 8'hA5;
    tick();
    nchk++;
    if (proto_err !== 1'b0 || ready !== 1'b0) begin
      nerr++;
      $display("FAIL proto_before: proto_err=%b ready=%b, need 0/0", proto_err, ready);
    end
    data = 8'h5A;
    tick();
    nchk++;
    if (proto_err !== 1'b1) begin
      nerr++;
      $display("FAIL proto_unstable: proto_err=%b, need 1", proto_err);
    end
    valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    nchk++;
    if (proto_err !== 1'b1 || level !== '0 || rx_count !== 32'd4) begin
      nerr++;
      $display("FAIL proto_sticky: proto_err=%b level=%0d rx_count=%0d, need 1/0/4", proto_err, level, rx_count);
    end
    // Withdrawal of an un-accepted word is the other violation.
    do_reset();
    out_ready = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data = DW'(8'h70 + i);
      tick();
    end
    data = 8'h77;
    tick();
    valid = 1'b0;
    tick();
    nchk++;
    if (proto_err !== 1'b1) begin
      nerr++;
      $display("FAIL proto_withdraw: proto_err=%b, need 1", proto_err);
    end
    do_reset();
    nchk++;
    if (proto_err !== 1'b0) begin
      nerr++;
      $display("FAIL proto_cleared: proto_err=%b, need 0", proto_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      data  = DW'(8'hC1 + i);
      tick();
    end
    nchk++;
    if (level !== LW'(3) || out_data !== 8'hC1) begin
      nerr++;
      $display("FAIL pre_async: level=%0d out_data=%h, need 3/c1", level, out_data);
    end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    nchk++;
    if (level !== '0 || out_valid !== 1'b0 || ready !== 1'b0 || rx_count !== '0) begin
      nerr++;
      $display("FAIL async_reset: level=%0d out_valid=%b ready=%b rx_count=%0d, need 0/0/0/0",
               level, out_valid, ready, rx_count);
    end
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    nchk++;
    if (out_valid !== 1'b0 || level !== '0) begin
      nerr++;
      $display("FAIL post_async: out_valid=%b level=%0d, need 0/0", out_valid, level);
    end
    valid = 1'b1;
    data  = 8'h99;
    tick();
    valid = 1'b0;
    out_ready = 1'b1;
    #1;
    nchk++;
    if (out_valid !== 1'b1 || out_data !== 8'h99 || level !== LW'(1)) begin
      nerr++;
      $display("FAIL post_async_word: out_valid=%b out_data=%h level=%0d, need 1/99/1", out_valid, out_data, level);
    end
    tick();
    nchk++;
    if (out_valid !== 1'b0 || rx_count !== 32'd1) begin
      nerr++;
      $display("FAIL post_async_empty: out_valid=%b rx_count=%0d, need 0/1", out_valid, rx_count);
    end
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_random();
    test_protocol();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
